// File: rtl/comb_bist_ctrl.sv
// rtl/comb_bist_ctrl.sv - exhaustive-sweep BIST controller for a combinational DUT; optional MISR via COMB_BIST_MISR_EN
module comb_bist_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] gold_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
`ifdef COMB_BIST_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [N_IN-1:0] vec;
    logic [SW-1:0]   cnt;
    logic            cmp_edge;
    logic            mismatch;
    logic            last_vec;

    assign cmp_edge = (state == S_APPLY) && (cnt == SW'(SETTLE - 1));
    assign mismatch = (dut_out != gold_out);
    assign last_vec = (vec == {N_IN{1'b1}});

    // dut_in is only driven with the sweep vector while applying; idle/done present zero
    assign dut_in = (state == S_APPLY) ? vec : '0;
    assign busy   = (state == S_APPLY);
    assign done   = (state == S_DONE);
    assign pass   = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            vec              <= '0;
            cnt              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state            <= S_APPLY;
                        vec              <= '0;
                        cnt              <= '0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (cmp_edge) begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        cnt <= '0;
                        if (last_vec) begin
                            state <= S_DONE;
                            vec   <= '0;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    vec   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef COMB_BIST_MISR_EN
    logic [15:0] misr_in;
    assign misr_in = 16'(dut_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            signature <= '0;
        end else if (cmp_edge) begin
            signature <= ({signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000)) ^ misr_in;
        end
    end
`endif

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// tb/tb_comb_bist_ctrl.sv - scoreboard bench for comb_bist_ctrl (N_IN=3, SETTLE=2, majority golden model)
module tb_comb_bist_ctrl;

    localparam int N_IN   = 3;
    localparam int N_OUT  = 1;
    localparam int SETTLE = 2;
    localparam int RUN_LEN = (1 << N_IN) * SETTLE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic [N_OUT-1:0] gold_out;
    logic             busy, done, pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_fail_vec;
    logic             first_fail_valid;
`ifdef COMB_BIST_MISR_EN
    logic [15:0]      signature;
`endif

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: dut=gold, 1: dut stuck-at-1, 2: dut stuck-at-0

    typedef struct {
        int errs;
        int ffvec;
        int ffvalid;
        int passv;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign gold_out = ((dut_in[0] & dut_in[1]) | (dut_in[0] & dut_in[2]) | (dut_in[1] & dut_in[2])) ? 1'b1 : 1'b0;
    assign dut_out  = (mode == 0) ? gold_out : (mode == 1) ? 1'b1 : 1'b0;

    comb_bist_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dut_in(dut_in),
        .dut_out(dut_out),
        .gold_out(gold_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid)
`ifdef COMB_BIST_MISR_EN
        ,
        .signature(signature)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: checks the sweep sequence while busy and pops the scoreboard on each done rise.
    int  busy_cnt  = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            check("dut_in_seq", int'(dut_in), busy_cnt / SETTLE);
            busy_cnt++;
        end
        if (busy === 1'b1 && done === 1'b1) check("busy_done_overlap", 1, 0);
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("run_len", busy_cnt, RUN_LEN);
                check("err_count", int'(err_count), e.errs);
                check("first_fail_vec", int'(first_fail_vec), e.ffvec);
                check("first_fail_valid", int'(first_fail_valid), e.ffvalid);
                check("pass", int'(pass), e.passv);
`ifdef COMB_BIST_MISR_EN
                if (mode == 2) check("signature", int'(signature), 0);
`endif
            end
            busy_cnt = 0;
        end
        if (rst === 1'b1) busy_cnt = 0;
        prev_done = done;
    end

    task automatic push_exp(input int errs, input int ffvec, input int ffvalid, input int passv);
        exp_t e;
        e.errs = errs; e.ffvec = ffvec; e.ffvalid = ffvalid; e.passv = passv;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) check({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_pass"}, int'(pass), 0);
        check({name, "_err"}, int'(err_count), 0);
        check({name, "_ffv"}, int'(first_fail_valid), 0);
        check({name, "_ffvec"}, int'(first_fail_vec), 0);
        check({name, "_dut_in"}, int'(dut_in), 0);
`ifdef COMB_BIST_MISR_EN
        check({name, "_sig"}, int'(signature), 0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b0;

        // fault-free run
        mode = 0; push_exp(0, 0, 0, 1);
        pulse_start(); wait_done("clean");

        // stuck-at-1: mismatches at 0,1,2,4; restart from DONE
        mode = 1; push_exp(4, 0, 1, 0);
        pulse_start(); wait_done("sa1");

        // stuck-at-0: mismatches at 3,5,6,7
        mode = 2; push_exp(4, 3, 1, 0);
        pulse_start(); wait_done("sa0");

        // repeat stuck-at-0 from DONE: identical results (and zero signature)
        push_exp(4, 3, 1, 0);
        pulse_start(); wait_done("sa0_again");

        // start pulsed mid-run is ignored
        mode = 0; push_exp(0, 0, 0, 1);
        pulse_start();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("mid_start");

        // reset at vector 5 aborts the run
        mode = 1;
        pulse_start();
        begin
            int n = 0;
            while (!(busy === 1'b1 && dut_in == 3'd5) && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("reach_vec5", int'(dut_in), 5);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_idle_outputs("mid_rst");

        // fresh run after abort
        push_exp(4, 0, 1, 0);
        pulse_start(); wait_done("post_rst");

        // rst and start together: rst wins
        @(posedge clk); #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        check_idle_outputs("rst_start");
        repeat (3) @(posedge clk);
        #1 check("rst_start_stay_idle", int'(busy), 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
